// File: rtl/noc_packetizer.sv
// NoC injection stage: turns a message descriptor plus payload words into a HEADER/DATA/TAIL wormhole packet.
// Optional build macro NOC_PACKETIZER_STATS_EN adds stat_pkts/stat_flits traffic counters.

package noc_pkg;
  localparam int FLIT_DATA_WIDTH        = 32;
  localparam int MESH_ADDR_X            = 4;
  localparam int MESH_ADDR_Y            = 4;
  localparam int FLIT_TAIL_LENGTH_WIDTH = 5;
  localparam int FLIT_TYPE_WIDTH        = 2;
  localparam int FLIT_WIDTH             = FLIT_TYPE_WIDTH + FLIT_DATA_WIDTH;
  localparam int HDR_PAD_WIDTH          = FLIT_DATA_WIDTH - MESH_ADDR_X - MESH_ADDR_Y
                                          - FLIT_TAIL_LENGTH_WIDTH;

  typedef enum logic [FLIT_TYPE_WIDTH-1:0] {
    FLIT_HEADER = 2'd0,
    FLIT_DATA   = 2'd1,
    FLIT_TAIL   = 2'd2
  } flit_type_t;

  typedef struct packed {
    logic [MESH_ADDR_X-1:0] x;
    logic [MESH_ADDR_Y-1:0] y;
  } addr_t;

  // Header payload layout, MSB first: destination, tail bit-length, zero padding.
  typedef struct packed {
    addr_t                             dst_addr;
    logic [FLIT_TAIL_LENGTH_WIDTH-1:0] tail_length;
    logic [HDR_PAD_WIDTH-1:0]          padding;
  } hdr_t;

  typedef struct packed {
    flit_type_t                 flit_type;
    logic [FLIT_DATA_WIDTH-1:0] payload;
  } flit_t;
endpackage

module noc_packetizer
  import noc_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              msg_valid,
  output logic                              msg_ready,
  input  addr_t                             msg_dst,
  input  logic [LEN_W-1:0]                  msg_len,
  input  logic [FLIT_TAIL_LENGTH_WIDTH-1:0] msg_tail_bits,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [FLIT_DATA_WIDTH-1:0]        in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
`ifdef NOC_PACKETIZER_STATS_EN
  output logic [31:0]                       stat_pkts,
  output logic [31:0]                       stat_flits,
`endif
  output flit_t                             out_flit
);

  typedef enum logic {IDLE, BODY} state_t;

  state_t           state;
  logic [LEN_W-1:0] remaining;

  logic slot_free;
  logic msg_fire;
  logic word_fire;
  logic empty_tail;
  hdr_t hdr;

  // The output register may take a new flit when it is empty or being drained this cycle.
  assign slot_free  = !out_valid || out_ready;
  assign msg_ready  = (state == IDLE) && slot_free;
  assign in_ready   = (state == BODY) && (remaining != '0) && slot_free;
  assign msg_fire   = msg_valid && msg_ready;
  assign word_fire  = in_valid && in_ready;
  assign empty_tail = (state == BODY) && (remaining == '0) && slot_free;

  assign hdr.dst_addr    = msg_dst;
  assign hdr.tail_length = msg_tail_bits;
  assign hdr.padding     = '0;

  // NOTE: state lives in always_ff with non-blocking assignments only, so every
  // register samples the pre-edge values and there is no ordering race between them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      out_valid <= 1'b0;
      out_flit  <= '0;
    end else begin
      if (slot_free) out_valid <= msg_fire || word_fire || empty_tail;

      case (state)
        IDLE: begin
          if (msg_fire) begin
            out_flit.flit_type <= FLIT_HEADER;
            out_flit.payload   <= hdr;
            remaining          <= msg_len;
            state              <= BODY;
          end
        end
        BODY: begin
          if (word_fire) begin
            out_flit.flit_type <= (remaining != LEN_W'(1)) ? FLIT_DATA : FLIT_TAIL;
            out_flit.payload   <= in_data;
            remaining          <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) state <= IDLE;
          end else if (empty_tail) begin
            // Zero-length message still needs a TAIL to close the wormhole.
            out_flit.flit_type <= FLIT_TAIL;
            out_flit.payload   <= '0;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NOC_PACKETIZER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts  <= '0;
      stat_flits <= '0;
    end else if (out_valid && out_ready) begin
      stat_flits <= stat_flits + 32'd1;
      if (out_flit.flit_type == FLIT_TAIL) stat_pkts <= stat_pkts + 32'd1;
    end
  end
`endif

endmodule
